// File: rtl/disp_arbiter_if.sv
// rtl/disp_arbiter_if.sv - request/grant and digit bus between display sources and the arbiter
interface disp_arbiter_if;
  logic [2:0]  req_i;
  logic [2:0]  flash_i;
  logic [15:0] data0_i;
  logic [15:0] data1_i;
  logic [15:0] data2_i;
  logic [3:0]  en0_i;
  logic [3:0]  en1_i;
  logic [3:0]  en2_i;
  logic [2:0]  gnt_o;
  logic        busy_o;
  logic [3:0]  digit0_o;
  logic [3:0]  digit1_o;
  logic [3:0]  digit2_o;
  logic [3:0]  digit3_o;
  logic        digit0_en_o;
  logic        digit1_en_o;
  logic        digit2_en_o;
  logic        digit3_en_o;

  modport master (
    output req_i, flash_i, data0_i, data1_i, data2_i, en0_i, en1_i, en2_i,
    input  gnt_o, busy_o, digit0_o, digit1_o, digit2_o, digit3_o,
    input  digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o
  );

  modport slave (
    input  req_i, flash_i, data0_i, data1_i, data2_i, en0_i, en1_i, en2_i,
    output gnt_o, busy_o, digit0_o, digit1_o, digit2_o, digit3_o,
    output digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o
  );
endinterface

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - fixed-priority preemptive display arbiter with minimum hold and flashing
module disp_arbiter #(
  parameter int HOLD_TICKS = 8,
  parameter int FLASH_DIV  = 2
) (
  input  logic          clk_4_i,
  input  logic          rst_ni,
  disp_arbiter_if.slave bus
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LINGER} state_t;
  typedef enum logic [1:0] {A_IDLE, A_GRANT, A_TRACK, A_FREEZE} act_t;

  state_t        state;
  act_t          act;
  logic [1:0]    owner;
  logic [HW-1:0] hold_cnt;
  logic [FW-1:0] flash_cnt;
  logic          phase;
  logic [15:0]   snap_data;
  logic [3:0]    snap_en;
  logic [2:0]    gnt_q;
  logic          busy_q;

  logic [1:0]    win_idx;
  logic [15:0]   win_data;
  logic [3:0]    win_en;
  logic [15:0]   own_data;
  logic [3:0]    own_en;
  logic          own_req;
  logic          own_flash;
  logic          own_valid;
  logic          higher_req;

  always_comb begin
    win_idx = 2'd2;
    if (bus.req_i[1]) win_idx = 2'd1;
    if (bus.req_i[0]) win_idx = 2'd0;
    case (win_idx)
      2'd0:    begin win_data = bus.data0_i; win_en = bus.en0_i; end
      2'd1:    begin win_data = bus.data1_i; win_en = bus.en1_i; end
      default: begin win_data = bus.data2_i; win_en = bus.en2_i; end
    endcase

    own_valid  = 1'b1;
    own_req    = 1'b0;
    own_flash  = 1'b0;
    higher_req = 1'b0;
    own_data   = 16'h0;
    own_en     = 4'h0;
    case (owner)
      2'd0: begin
        own_req = bus.req_i[0]; own_flash = bus.flash_i[0];
        own_data = bus.data0_i; own_en = bus.en0_i;
      end
      2'd1: begin
        own_req = bus.req_i[1]; own_flash = bus.flash_i[1];
        own_data = bus.data1_i; own_en = bus.en1_i;
        higher_req = bus.req_i[0];
      end
      2'd2: begin
        own_req = bus.req_i[2]; own_flash = bus.flash_i[2];
        own_data = bus.data2_i; own_en = bus.en2_i;
        higher_req = |bus.req_i[1:0];
      end
      default: own_valid = 1'b0;
    endcase

    // Preemption is tested before release so a simultaneous pair never lingers.
    act = A_IDLE;
    case (state)
      S_IDLE:   act = (|bus.req_i) ? A_GRANT : A_IDLE;
      S_ACTIVE: begin
        if (!own_valid)      act = A_IDLE;
        else if (higher_req) act = A_GRANT;
        else if (!own_req)   act = A_FREEZE;
        else                 act = A_TRACK;
      end
      S_LINGER: begin
        if (!own_valid)                 act = A_IDLE;
        else if (higher_req)            act = A_GRANT;
        else if (own_req)               act = A_TRACK;
        else if (hold_cnt == HOLD_MAX)  act = (|bus.req_i) ? A_GRANT : A_IDLE;
        else                            act = A_FREEZE;
      end
      default:  act = A_IDLE;
    endcase
  end

  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      owner     <= 2'd0;
      hold_cnt  <= '0;
      flash_cnt <= '0;
      phase     <= 1'b1;
      snap_data <= 16'h0;
      snap_en   <= 4'h0;
      gnt_q     <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      case (act)
        A_GRANT: begin
          state     <= S_ACTIVE;
          owner     <= win_idx;
          hold_cnt  <= '0;
          flash_cnt <= '0;
          phase     <= 1'b1;
          snap_data <= win_data;
          snap_en   <= win_en;
          gnt_q     <= 3'(3'b001 << win_idx);
          busy_q    <= 1'b1;
        end
        A_TRACK, A_FREEZE: begin
          state <= (act == A_TRACK) ? S_ACTIVE : S_LINGER;
          if (act == A_TRACK) begin
            snap_data <= own_data;
            snap_en   <= own_en;
          end
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
          if (!own_flash) begin
            flash_cnt <= '0;
            phase     <= 1'b1;
          end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            phase     <= ~phase;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          owner     <= 2'd0;
          hold_cnt  <= '0;
          flash_cnt <= '0;
          phase     <= 1'b1;
          snap_data <= 16'h0;
          snap_en   <= 4'h0;
          gnt_q     <= 3'b000;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.busy_o      = busy_q;
  assign bus.digit0_o    = snap_data[3:0];
  assign bus.digit1_o    = snap_data[7:4];
  assign bus.digit2_o    = snap_data[11:8];
  assign bus.digit3_o    = snap_data[15:12];
  assign bus.digit0_en_o = snap_en[0] & phase;
  assign bus.digit1_en_o = snap_en[1] & phase;
  assign bus.digit2_en_o = snap_en[2] & phase;
  assign bus.digit3_en_o = snap_en[3] & phase;
endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - scoreboard bench for disp_arbiter
module tb_disp_arbiter;
  logic clk_4_i = 1'b0;
  logic rst_ni  = 1'b0;

  disp_arbiter_if bus ();

  disp_arbiter #(.HOLD_TICKS(8), .FLASH_DIV(2)) dut (
    .clk_4_i (clk_4_i),
    .rst_ni  (rst_ni),
    .bus     (bus)
  );

  always #5 clk_4_i = ~clk_4_i;

  typedef struct {
    string       tag;
    logic [23:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [23:0] outs;
  assign outs = {bus.gnt_o, bus.busy_o,
                 bus.digit3_o, bus.digit2_o, bus.digit1_o, bus.digit0_o,
                 bus.digit3_en_o, bus.digit2_en_o, bus.digit1_en_o, bus.digit0_en_o};

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt/busy/digits/en=%h required %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] g, input logic b,
                            input logic [15:0] d, input logic [3:0] e);
    exp_t x;
    x.tag = tag;
    x.val = {g, b, d, e};
    sb_q.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    x = sb_q.pop_front();
    check_eq(x.tag, outs, x.val);
  endtask

  task automatic step(input string tag, input logic [2:0] g, input logic b,
                      input logic [15:0] d, input logic [3:0] e);
    expect_out(tag, g, b, d, e);
    @(posedge clk_4_i);
    #1;
    compare_out();
  endtask

  logic [3:0] flash_pat [6];

  initial begin
    flash_pat[0] = 4'hF; flash_pat[1] = 4'h0; flash_pat[2] = 4'h0;
    flash_pat[3] = 4'hF; flash_pat[4] = 4'hF; flash_pat[5] = 4'h0;

    bus.req_i = 3'b000; bus.flash_i = 3'b000;
    bus.data0_i = 16'h0; bus.data1_i = 16'h0; bus.data2_i = 16'h0;
    bus.en0_i = 4'h0; bus.en1_i = 4'h0; bus.en2_i = 4'h0;
    #1;
    expect_out("reset", 3'b000, 1'b0, 16'h0, 4'h0);
    compare_out();
    @(negedge clk_4_i);
    rst_ni = 1'b1;

    // lowest priority gets the idle display, data tracks one cycle behind
    bus.req_i = 3'b100; bus.data2_i = 16'h1234; bus.en2_i = 4'hF;
    step("grant2", 3'b100, 1'b1, 16'h1234, 4'hF);
    bus.data2_i = 16'h5678;
    step("track2", 3'b100, 1'b1, 16'h5678, 4'hF);

    // requester 0 preempts, releases, lingers frozen for the hold, then 2 returns
    bus.req_i = 3'b101; bus.data0_i = 16'hABCD; bus.en0_i = 4'h3;
    step("preempt0", 3'b001, 1'b1, 16'hABCD, 4'h3);
    bus.req_i = 3'b100; bus.data0_i = 16'h0000;
    for (int i = 0; i < 8; i++) step("linger0", 3'b001, 1'b1, 16'hABCD, 4'h3);
    step("regrant2", 3'b100, 1'b1, 16'h5678, 4'hF);

    // owner 2 releases as 0 requests: direct switch
    bus.req_i = 3'b001; bus.data0_i = 16'h9ABC; bus.en0_i = 4'hF;
    step("swap0", 3'b001, 1'b1, 16'h9ABC, 4'hF);
    step("track0", 3'b001, 1'b1, 16'h9ABC, 4'hF);
    bus.req_i = 3'b011; bus.data1_i = 16'h4321; bus.en1_i = 4'hF;
    step("low1wait", 3'b001, 1'b1, 16'h9ABC, 4'hF);
    bus.req_i = 3'b010; bus.data0_i = 16'h0000;
    for (int i = 0; i < 6; i++) step("hold0", 3'b001, 1'b1, 16'h9ABC, 4'hF);
    step("grant1", 3'b010, 1'b1, 16'h4321, 4'hF);

    // flash bits of non-owners are ignored; the owner's bit blinks the enables
    bus.flash_i = 3'b101;
    step("flash_other", 3'b010, 1'b1, 16'h4321, 4'hF);
    bus.flash_i = 3'b010;
    for (int i = 0; i < 6; i++) step("flash_pat", 3'b010, 1'b1, 16'h4321, flash_pat[i]);
    bus.flash_i = 3'b000;
    step("flash_off", 3'b010, 1'b1, 16'h4321, 4'hF);

    // asynchronous reset during LINGER
    bus.req_i = 3'b000;
    step("linger1", 3'b010, 1'b1, 16'h4321, 4'hF);
    #2;
    rst_ni = 1'b0;
    #1;
    expect_out("async_rst", 3'b000, 1'b0, 16'h0, 4'h0);
    compare_out();
    @(negedge clk_4_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst", 3'b000, 1'b0, 16'h0, 4'h0);

    // released grant with nobody waiting returns to idle after the hold
    bus.req_i = 3'b001; bus.data0_i = 16'h0F0F; bus.en0_i = 4'hA;
    step("grant0", 3'b001, 1'b1, 16'h0F0F, 4'hA);
    bus.req_i = 3'b000;
    for (int i = 0; i < 8; i++) step("linger_idle", 3'b001, 1'b1, 16'h0F0F, 4'hA);
    step("to_idle", 3'b000, 1'b0, 16'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
